// File: rtl/keypad_bcd_encoder.sv
// 4x4 matrix keypad scanner with press/release debounce and BCD encoding of digit keys.
// Holds the last accepted digit on A..D and emits one strobe per debounced press.
module keypad_bcd_encoder #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       key_valid,
  output logic       key_nondigit
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // {found, index} of the lowest-indexed low row
  function automatic logic [2:0] lowest_low(input logic [3:0] v);
    logic [2:0] res;
    if (!v[0]) begin
      res = {1'b1, 2'd0};
    end else if (!v[1]) begin
      res = {1'b1, 2'd1};
    end else if (!v[2]) begin
      res = {1'b1, 2'd2};
    end else if (!v[3]) begin
      res = {1'b1, 2'd3};
    end else begin
      res = {1'b0, 2'd0};
    end
    return res;
  endfunction

  // {is_digit, bcd} for a key position
  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] res;
    case ({r, c})
      4'b00_00: res = {1'b1, 4'd1};
      4'b00_01: res = {1'b1, 4'd2};
      4'b00_10: res = {1'b1, 4'd3};
      4'b01_00: res = {1'b1, 4'd4};
      4'b01_01: res = {1'b1, 4'd5};
      4'b01_10: res = {1'b1, 4'd6};
      4'b10_00: res = {1'b1, 4'd7};
      4'b10_01: res = {1'b1, 4'd8};
      4'b10_10: res = {1'b1, 4'd9};
      4'b11_01: res = {1'b1, 4'd0};
      default:  res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] res;
    case (idx)
      2'd0:    res = 4'b1110;
      2'd1:    res = 4'b1101;
      2'd2:    res = 4'b1011;
      2'd3:    res = 4'b0111;
      default: res = 4'b1110;
    endcase
    return res;
  endfunction

  logic [3:0]       rs_meta_r, rs_r;
  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       col_idx_r, col_idx_s;
  logic [1:0]       key_row_r, key_row_s;
  logic [3:0]       col_r;
  logic [3:0]       abcd_r, abcd_s;
  logic             key_valid_r, key_valid_s;
  logic             key_nondigit_r, key_nondigit_s;
  logic [2:0]       win_s;
  logic [4:0]       key_s;

  assign win_s = lowest_low(rs_r);
  assign key_s = key_code(key_row_r, col_idx_r);

  // two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta_r <= 4'b1111;
      rs_r      <= 4'b1111;
    end else begin
      rs_meta_r <= row;
      rs_r      <= rs_meta_r;
    end
  end

  // scan / debounce / held next-state and strobe decisions
  always_comb begin
    state_s        = state_r;
    div_cnt_s      = div_cnt_r;
    cnt_s          = cnt_r;
    col_idx_s      = col_idx_r;
    key_row_s      = key_row_r;
    abcd_s         = abcd_r;
    key_valid_s    = 1'b0;
    key_nondigit_s = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (div_cnt_r == DIV_W'(SCAN_DIV - 1)) begin
          div_cnt_s = '0;
          if (rs_r != 4'hF) begin
            state_s   = ST_DEBOUNCE;
            key_row_s = win_s[1:0];
            cnt_s     = CNT_W'(1);
          end else begin
            col_idx_s = col_idx_r + 2'd1;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (win_s[2] && (win_s[1:0] == key_row_r)) begin
          if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_s = ST_HELD;
            cnt_s   = '0;
            if (key_s[4]) begin
              abcd_s      = key_s[3:0];
              key_valid_s = 1'b1;
            end else begin
              key_nondigit_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          // bounce or glitch: abandon this key and carry on scanning
          state_s   = ST_SCAN;
          cnt_s     = '0;
          div_cnt_s = '0;
          col_idx_s = col_idx_r + 2'd1;
        end
      end
      ST_HELD: begin
        if (rs_r[key_row_r]) begin
          if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_s   = ST_SCAN;
            cnt_s     = '0;
            div_cnt_s = '0;
            col_idx_s = col_idx_r + 2'd1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = '0;
        end
      end
      default: begin
        state_s   = ST_SCAN;
        cnt_s     = '0;
        div_cnt_s = '0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_SCAN;
      div_cnt_r      <= '0;
      cnt_r          <= '0;
      col_idx_r      <= 2'd0;
      key_row_r      <= 2'd0;
      col_r          <= 4'b1110;
      abcd_r         <= 4'b0000;
      key_valid_r    <= 1'b0;
      key_nondigit_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      div_cnt_r      <= div_cnt_s;
      cnt_r          <= cnt_s;
      col_idx_r      <= col_idx_s;
      key_row_r      <= key_row_s;
      col_r          <= col_drive(col_idx_s);
      abcd_r         <= abcd_s;
      key_valid_r    <= key_valid_s;
      key_nondigit_r <= key_nondigit_s;
    end
  end

  assign col          = col_r;
  assign A            = abcd_r[3];
  assign B            = abcd_r[2];
  assign C            = abcd_r[1];
  assign D            = abcd_r[0];
  assign key_valid    = key_valid_r;
  assign key_nondigit = key_nondigit_r;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: physical keypad model, behavioural reference and
// directed plus random key presses.
module tb_keypad_bcd_encoder;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       A, B, C, D, key_valid, key_nondigit;
  logic [15:0] pk = 16'h0000;

  int checks = 0;
  int failures = 0;
  int kv_seen = 0;
  int nd_seen = 0;

  keypad_bcd_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .A(A), .B(B), .C(C), .D(D),
    .key_valid(key_valid), .key_nondigit(key_nondigit)
  );

  always #5 clk = ~clk;

  // pressed switches connect a row to whichever column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pk[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // reference model: key values, -1 marks a non-digit key
  int keymap [4][4] = '{'{1, 2, 3, -1}, '{4, 5, 6, -1}, '{7, 8, 9, -1}, '{-1, 0, -1, -1}};
  int m_pos, m_phase, m_tick, m_run, m_krow, m_code;
  logic [3:0] m_s1, m_s2;
  bit m_kv, m_knd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_phase = 0; m_tick = 0; m_run = 0; m_krow = 0; m_code = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_kv = 1'b0; m_knd = 1'b0;
  endtask

  function automatic int winner(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic advance_col();
    m_pos = (m_pos + 1) % 4; m_tick = 0; m_run = 0; m_phase = 0;
  endtask

  task automatic model_step(input logic [3:0] pin);
    logic [3:0] rs;
    rs = m_s2; m_s2 = m_s1; m_s1 = pin;
    m_kv = 1'b0; m_knd = 1'b0;
    if (m_phase == 0) begin
      if (m_tick == SD - 1) begin
        m_tick = 0;
        if (rs != 4'hF) begin m_phase = 1; m_krow = winner(rs); m_run = 1; end
        else m_pos = (m_pos + 1) % 4;
      end else m_tick++;
    end else if (m_phase == 1) begin
      if (winner(rs) == m_krow) begin
        m_run++;
        if (m_run == DB) begin
          m_phase = 2; m_run = 0;
          if (keymap[m_krow][m_pos] >= 0) begin m_code = keymap[m_krow][m_pos]; m_kv = 1'b1; end
          else m_knd = 1'b1;
        end
      end else advance_col();
    end else begin
      if (rs[m_krow]) begin
        m_run++;
        if (m_run == DB) advance_col();
      end else m_run = 0;
    end
  endtask

  // step the model on each rising edge, compare every falling edge
  initial begin
    logic [3:0] smp, ecol;
    model_reset();
    forever begin
      @(posedge clk);
      smp = row;
      if (!rst_n) model_reset(); else model_step(smp);
      @(negedge clk);
      if (!rst_n) model_reset();
      ecol = 4'b1111 ^ (4'b0001 << m_pos);
      chk("col", col, ecol);
      chk("abcd", {A, B, C, D}, m_code[3:0]);
      chk("key_valid", key_valid, m_kv);
      chk("key_nondigit", key_nondigit, m_knd);
      if (key_valid) kv_seen++;
      if (key_nondigit) nd_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // wait for the start of a fresh dwell on column c
  task automatic wait_col(input int c);
    logic [3:0] tgt;
    int n;
    tgt = 4'b1111 ^ (4'b0001 << c);
    n = 0;
    while (col === tgt && n < 64) begin @(negedge clk); n++; end
    while (col !== tgt && n < 128) begin @(negedge clk); n++; end
    chk("wait_col", col, tgt);
  endtask

  task automatic press(input int r, input int c, input int hold);
    wait_col(c);
    pk[r*4+c] = 1'b1;
    idle(hold);
    pk = 16'h0000;
  endtask

  logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int kv0, nd0, n, r, c, hold;
    idle(3);
    rst_n = 1'b1;
    // 1: idle scanning
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("scan_seq", col, pat[(k / 4) % 4]);
    end
    chk("idle_abcd", {A, B, C, D}, 4'b0000);
    chk("idle_strobes", kv_seen + nd_seen, 0);

    // 2: key '7' with pinned latency
    kv0 = kv_seen;
    wait_col(0);
    pk[2*4+0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!key_valid && n < 40);
    chk("latency7", n, 11);
    idle(25);
    chk("frozen_col", col, 4'b1110);
    pk = 16'h0000;
    idle(20);
    chk("kv7_count", kv_seen - kv0, 1);
    chk("abcd7", {A, B, C, D}, 4'b0111);

    // 3: '0' then '9'
    kv0 = kv_seen;
    press(3, 1, 20); idle(20);
    chk("abcd0", {A, B, C, D}, 4'b0000);
    press(2, 2, 20); idle(20);
    chk("abcd9", {A, B, C, D}, 4'b1001);
    chk("kv09_count", kv_seen - kv0, 2);

    // 4: '5' then '#'
    press(1, 1, 20); idle(20);
    chk("abcd5", {A, B, C, D}, 4'b0101);
    kv0 = kv_seen; nd0 = nd_seen;
    press(3, 2, 20); idle(20);
    chk("nd_count", nd_seen - nd0, 1);
    chk("nd_no_kv", kv_seen - kv0, 0);
    chk("abcd_after_nd", {A, B, C, D}, 4'b0101);

    // 5: bouncing '3', then a too-short press
    kv0 = kv_seen;
    press(0, 2, 3); idle(2);
    pk[0*4+2] = 1'b1; idle(40); pk = 16'h0000; idle(20);
    chk("bounce_kv", kv_seen - kv0, 1);
    chk("abcd3", {A, B, C, D}, 4'b0011);
    kv0 = kv_seen; nd0 = nd_seen;
    press(0, 2, 5); idle(20);
    chk("glitch_strobes", (kv_seen - kv0) + (nd_seen - nd0), 0);
    chk("glitch_abcd", {A, B, C, D}, 4'b0011);

    // 6: reset while holding '8'
    wait_col(1);
    pk[2*4+1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!key_valid && n < 40);
    idle(3);
    chk("abcd8", {A, B, C, D}, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abcd", {A, B, C, D}, 4'b0000);
    chk("rst_col", col, 4'b1110);
    chk("rst_strobes", {key_valid, key_nondigit}, 2'b00);
    pk = 16'h0000;
    idle(3);
    rst_n = 1'b1;
    idle(20);

    // random presses, sometimes two keys together
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      hold = $urandom_range(1, 30);
      if ($urandom_range(0, 1) == 1) wait_col(c);
      pk[r*4+c] = 1'b1;
      if ($urandom_range(0, 3) == 0) pk[$urandom_range(0, 15)] = 1'b1;
      idle(hold);
      pk = 16'h0000;
      idle($urandom_range(0, 25));
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
